soc_system_random_arbiter: RTL and testbench



---
 rtl/soc_system_random_pkg.sv | 21 ++
 rtl/soc_system_rr_arbiter.sv | 47 ++++
 rtl/soc_system_random_arbiter.sv | 119 +++++++++++
 tb/tb_soc_system_random_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_random_pkg.sv
// Shared types and constants for the random-word arbiter: FSM states,
// datapath widths and the legal parameter bounds.
package soc_system_random_pkg;

    localparam int RND_W = 32;
    localparam int GAP_W = 8;
    localparam int REP_W = 4;
    localparam int IDX_W = 3;

    localparam int NUM_REQ_MIN      = 2;
    localparam int NUM_REQ_MAX      = 8;
    localparam int MIN_GAP_MAX      = 255;
    localparam int REPEAT_LIMIT_MIN = 2;
    localparam int REPEAT_LIMIT_MAX = 15;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_DELIVER = 1'b1
    } state_t;

endpackage

// File: rtl/soc_system_rr_arbiter.sv
// Combinational round-robin picker: the first set request after last_winner
// (wrapping modulo NUM_REQ) wins.
module soc_system_rr_arbiter
    import soc_system_random_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner
);

    logic [NUM_REQ_MAX-1:0] req_ext;
    logic                   found;

    always_comb begin
        int             sum;
        logic [IDX_W-1:0] idx;
        // NOTE: every output gets a default first, so no path through the loop infers a latch.
        req_ext               = '0;
        req_ext[NUM_REQ-1:0]  = req;
        found                 = 1'b0;
        winner                = '0;
        sum                   = 0;
        idx                   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            sum = int'(last_winner) + off;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IDX_W'(sum);
            if (!found && req_ext[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = found && (winner == IDX_W'(i));
        end
    end

endmodule

// File: rtl/soc_system_random_arbiter.sv
// Round-robin sharing of one 32-bit random source with an enforced idle gap.
// Define SOC_SYSTEM_RANDOM_HEALTH_EN to add the stuck-source repeat check.
module soc_system_random_arbiter
    import soc_system_random_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MIN_GAP      = 3,
    parameter int REPEAT_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RND_W-1:0]   rnd_in,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic [RND_W-1:0]   rnd_out,
    output logic               busy,
    output logic               src_fault
);

    if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX ||
        MIN_GAP < 0 || MIN_GAP > MIN_GAP_MAX ||
        REPEAT_LIMIT < REPEAT_LIMIT_MIN || REPEAT_LIMIT > REPEAT_LIMIT_MAX) begin : g_bad_params
        $error("soc_system_random_arbiter: parameter out of legal range");
    end

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   last_winner;
    logic [IDX_W-1:0]   winner_q;
    logic [RND_W-1:0]   sample;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   winner;
    logic               capture_ok;
    logic               repeat_hit;
    logic               capture;

    soc_system_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req         (req),
        .last_winner (last_winner),
        .grant       (grant),
        .winner      (winner)
    );

    // A would-be capture: the health check may still veto it on a repeat.
    assign capture_ok = (state == ST_IDLE) && (req != '0) &&
                        (gap_cnt == '0) && !src_fault;
    assign capture    = capture_ok && !repeat_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            last_winner <= IDX_W'(NUM_REQ - 1);
            winner_q    <= '0;
            // NOTE: the sample register is reset because the repeat check compares against it.
            sample      <= '0;
            ack         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        sample   <= rnd_in;
                        winner_q <= winner;
                        ack      <= grant;
                        state    <= ST_DELIVER;
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                ST_DELIVER: begin
                    ack         <= '0;
                    last_winner <= winner_q;
                    gap_cnt     <= GAP_W'(MIN_GAP);
                    state       <= ST_IDLE;
                end
                default: begin
                    ack   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero outside the delivery cycle so consumers can OR the words together.
    assign rnd_out = (state == ST_DELIVER) ? sample : '0;
    assign busy    = (state == ST_DELIVER) || (gap_cnt != '0);

`ifdef SOC_SYSTEM_RANDOM_HEALTH_EN
    logic [REP_W-1:0] rep_cnt;
    logic             fault_q;

    assign repeat_hit = (rnd_in == sample);

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt <= '0;
            fault_q <= 1'b0;
        end else if (capture_ok) begin
            if (repeat_hit) begin
                rep_cnt <= rep_cnt + REP_W'(1);
                if (rep_cnt == REP_W'(REPEAT_LIMIT - 1)) begin
                    fault_q <= 1'b1;
                end
            end else begin
                rep_cnt <= '0;
            end
        end
    end

    assign src_fault = fault_q;
`else
    assign repeat_hit = 1'b0;
    assign src_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_soc_system_random_arbiter.sv
// Scoreboard bench for soc_system_random_arbiter: stimulus queues expected acks,
// a negedge monitor pops and compares them.
module tb_soc_system_random_arbiter;
    import soc_system_random_pkg::*;

    localparam int NUM_REQ      = 4;
    localparam int MIN_GAP      = 3;
    localparam int REPEAT_LIMIT = 4;
    localparam int SPACING      = MIN_GAP + 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [31:0]        rnd_in = '0;
    logic [NUM_REQ-1:0] req = '0;
    logic [NUM_REQ-1:0] ack;
    logic [31:0]        rnd_out;
    logic               busy;
    logic               src_fault;

    typedef struct {
        logic [NUM_REQ-1:0] ack;
        logic [31:0]        data;
        int                 cycle;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        free_run = 1'b0;
    logic [31:0] fixed_word = '0;

    soc_system_random_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .MIN_GAP      (MIN_GAP),
        .REPEAT_LIMIT (REPEAT_LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rnd_in    (rnd_in),
        .req       (req),
        .ack       (ack),
        .rnd_out   (rnd_out),
        .busy      (busy),
        .src_fault (src_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source model: in free-run mode the word of cycle k is {C0DE, k}.
    function automatic logic [31:0] rw(input int k);
        logic [31:0] kv;
        kv = 32'(k);
        return {16'hC0DE, kv[15:0]};
    endfunction

    always @(posedge clk) begin
        #2;
        rnd_in = free_run ? rw(cyc) : fixed_word;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    task automatic expect_ack(input logic [NUM_REQ-1:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.ack   = a;
        e.data  = d;
        e.cycle = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        ticks(2);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (cyc >= 1) begin
            if (ack !== '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_vec", 32'(ack), 32'(e.ack));
                    check("ack_data", rnd_out, e.data);
                    check("ack_cycle", 32'(cyc), 32'(e.cycle));
                end
            end else begin
                check("rnd_out_zero_idle", rnd_out, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c;

        do_reset();
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_rnd_out", rnd_out, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_src_fault", 32'(src_fault), 32'd0);

        // Single requester held: first word now, second no earlier than MIN_GAP+2.
        free_run   = 1'b0;
        fixed_word = 32'hA5A5_0001;
        req        = 4'b0001;
        c          = cyc;
        expect_ack(4'b0001, 32'hA5A5_0001, c + 1);
        expect_ack(4'b0001, 32'hA5A5_0002, c + 1 + SPACING);
        tick();
        fixed_word = 32'hA5A5_0002;
        check("busy_deliver", 32'(busy), 32'd1);
        ticks(3);
        check("busy_gap_last", 32'(busy), 32'd1);
        tick();
        check("busy_gap_done", 32'(busy), 32'd0);
        tick();
        req = '0;
        ticks(6);

        // All four held from reset: order 0,1,2,3,0 at 5-cycle spacing.
        do_reset();
        check("reset2_ack", 32'(ack), 32'd0);
        free_run = 1'b1;
        req      = 4'b1111;
        c        = cyc;
        for (int k = 0; k < 5; k++) begin
            expect_ack(NUM_REQ'(1 << (k % 4)), rw(c + k * SPACING), c + 1 + k * SPACING);
        end
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t % SPACING == 0) check("rr_busy_capture", 32'(busy), 32'd0);
            else if (t % SPACING == 2) check("rr_busy_gap", 32'(busy), 32'd1);
        end
        tick();
        req = '0;
        ticks(8);

        // Reset in the DELIVER cycle, then a fresh request is served cleanly.
        req = 4'b0001;
        c   = cyc;
        expect_ack(4'b0001, rw(c), c + 1);
        tick();
        reset = 1'b1;
        tick();
        check("ack_after_reset", 32'(ack), 32'd0);
        check("rnd_out_after_reset", rnd_out, 32'd0);
        check("busy_after_reset", 32'(busy), 32'd0);
        reset = 1'b0;
        req   = 4'b0100;
        expect_ack(4'b0100, rw(c + 2), c + 3);
        tick();
        req = '0;
        ticks(6);

        // Request withdrawn in the DELIVER cycle: exactly one ack.
        req = 4'b0010;
        c   = cyc;
        expect_ack(4'b0010, rw(c), c + 1);
        tick();
        req = '0;
        ticks(10);

        // Source stuck at one value.
        do_reset();
        free_run   = 1'b0;
        fixed_word = 32'h1234_5678;
        req        = 4'b0001;
        c          = cyc;
`ifdef SOC_SYSTEM_RANDOM_HEALTH_EN
        expect_ack(4'b0001, 32'h1234_5678, c + 1);
        ticks(8);
        check("fault_before_limit", 32'(src_fault), 32'd0);
        tick();
        check("fault_at_limit", 32'(src_fault), 32'd1);
        ticks(20);
        check("fault_sticky", 32'(src_fault), 32'd1);
        do_reset();
        check("fault_cleared", 32'(src_fault), 32'd0);
`else
        for (int k = 0; k < 4; k++) begin
            expect_ack(4'b0001, 32'h1234_5678, c + 1 + k * SPACING);
        end
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t % SPACING == 1) check("no_fault", 32'(src_fault), 32'd0);
        end
        req = '0;
        ticks(8);
`endif

        ticks(3);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
